// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared word/address types and fetch-side constants for the CPU
package cpu_pkg;

  typedef logic [31:0] word_t;
  typedef logic [3:0]  reg_addr_t;

  localparam word_t     PC_STEP  = 32'd4;
  localparam reg_addr_t R15_ADDR = 4'hF;

endpackage

// File: rtl/pc_incr_adder.sv
// rtl/pc_incr_adder.sv - combinational M-bit adder, wraps modulo 2**M, no carry out
module pc_incr_adder #(
  parameter int M = 32
) (
  input  logic [M-1:0] a,
  input  logic [M-1:0] b,
  output logic [M-1:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/pc_regfile_unit.sv
// rtl/pc_regfile_unit.sv - PC register, PC+4/PC+8 incrementers and 2R1W register file (R15 reads PC+8)
// Optional build macro REGFILE_BYPASS_EN: forwards same-cycle write data to matching read ports.
module pc_regfile_unit
  import cpu_pkg::*;
#(
  parameter int          N        = 4,
  parameter int          M        = 32,
  parameter logic [M-1:0] PC_RESET = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [M-1:0] pc_next,
  output logic [M-1:0] pc,
  output logic [M-1:0] pc_plus4,
  output logic [M-1:0] pc_plus8,
  input  logic         we3,
  input  logic [N-1:0] a1,
  input  logic [N-1:0] a2,
  input  logic [N-1:0] a3,
  input  logic [M-1:0] wd3,
  output logic [M-1:0] rd1,
  output logic [M-1:0] rd2
);

  localparam int           NPHYS    = (2 ** N) - 1;
  localparam logic [N-1:0] PC_RADDR = {N{1'b1}};
  localparam logic [M-1:0] STEP     = M'(PC_STEP);

  logic [M-1:0] pc_q, pc_d;
  logic [M-1:0] regs_q [NPHYS];
  logic [M-1:0] regs_d [NPHYS];
  logic         wr_en;

  assign wr_en = we3 && (a3 != PC_RADDR);

  always_comb begin
    pc_d   = pc_next;
    regs_d = regs_q;
    if (wr_en) regs_d[a3] = wd3;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pc_q <= PC_RESET;
    else        pc_q <= pc_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NPHYS; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  assign pc = pc_q;

  pc_incr_adder #(.M(M)) u_add4 (
    .a   (pc_q),
    .b   (STEP),
    .sum (pc_plus4)
  );

  pc_incr_adder #(.M(M)) u_add8 (
    .a   (pc_plus4),
    .b   (STEP),
    .sum (pc_plus8)
  );

  // R15 is never a physical register, so it bypasses both the array and any forwarding.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (a1 == PC_RADDR) rd1 = pc_plus8;
`ifdef REGFILE_BYPASS_EN
    else if (wr_en && (a1 == a3)) rd1 = wd3;
`endif
    else rd1 = regs_q[a1];

    if (a2 == PC_RADDR) rd2 = pc_plus8;
`ifdef REGFILE_BYPASS_EN
    else if (wr_en && (a2 == a3)) rd2 = wd3;
`endif
    else rd2 = regs_q[a2];
  end

endmodule

// File: tb/tb_pc_regfile_unit.sv
// tb/tb_pc_regfile_unit.sv - directed self-checking bench for pc_regfile_unit
module tb_pc_regfile_unit;

  logic        clk;
  logic        reset;
  logic [31:0] pc_next;
  logic [31:0] pc, pc_plus4, pc_plus8;
  logic        we3;
  logic [3:0]  a1, a2, a3;
  logic [31:0] wd3;
  logic [31:0] rd1, rd2;

  int n_checks = 0;
  int n_fail   = 0;

  pc_regfile_unit #(.N(4), .M(32), .PC_RESET(32'h0)) dut (
    .clk      (clk),
    .reset    (reset),
    .pc_next  (pc_next),
    .pc       (pc),
    .pc_plus4 (pc_plus4),
    .pc_plus8 (pc_plus8),
    .we3      (we3),
    .a1       (a1),
    .a2       (a2),
    .a3       (a3),
    .wd3      (wd3),
    .rd1      (rd1),
    .rd2      (rd2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_r;

    reset   = 1'b0;
    pc_next = 32'h40;
    we3     = 1'b0;
    a1      = 4'd0;
    a2      = 4'd0;
    a3      = 4'd0;
    wd3     = 32'h0;

    // Reset held across edges
    tick();
    tick();
    check_eq("rst_pc", pc, 32'h0);
    check_eq("rst_pc4", pc_plus4, 32'h4);
    check_eq("rst_pc8", pc_plus8, 32'h8);
    for (int i = 0; i < 15; i++) begin
      a1 = 4'(i);
      a2 = 4'(14 - i);
      #1;
      check_eq($sformatf("rst_rd1_r%0d", i), rd1, 32'h0);
      check_eq($sformatf("rst_rd2_r%0d", 14 - i), rd2, 32'h0);
    end
    a1 = 4'hF;
    #1;
    check_eq("rst_r15", rd1, 32'h8);

    // PC stepping
    reset = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      pc_next = pc_plus4;
      tick();
      check_eq($sformatf("step_pc_%0d", k), pc, 32'(4 * k));
    end
    pc_next = 32'hFFFF_FFFC;
    tick();
    check_eq("wrap_pc", pc, 32'hFFFF_FFFC);
    check_eq("wrap_pc4", pc_plus4, 32'h0);
    check_eq("wrap_pc8", pc_plus8, 32'h4);

    // Write then read, including same-cycle read before the edge
    we3 = 1'b1; a3 = 4'd5; wd3 = 32'hDEAD_BEEF; a1 = 4'd5; a2 = 4'd5;
    #1;
`ifdef REGFILE_BYPASS_EN
    exp_r = 32'hDEAD_BEEF;
`else
    exp_r = 32'h0;
`endif
    check_eq("same_cyc_rd1", rd1, exp_r);
    check_eq("same_cyc_rd2", rd2, exp_r);
    tick();
    we3 = 1'b0;
    #1;
    check_eq("wr_rd1", rd1, 32'hDEAD_BEEF);
    check_eq("wr_rd2", rd2, 32'hDEAD_BEEF);

    // R15 read and ignored R15 write
    pc_next = 32'h100;
    tick();
    a1 = 4'hF;
    #1;
    check_eq("r15_rd1", rd1, 32'h108);
    we3 = 1'b1; a3 = 4'hF; wd3 = 32'h1234;
    tick();
    we3 = 1'b0;
    #1;
    check_eq("r15_wr_pc", pc, 32'h100);
    check_eq("r15_wr_rd1", rd1, 32'h108);
    for (int i = 0; i < 15; i++) begin
      a2 = 4'(i);
      #1;
      check_eq($sformatf("r15_wr_r%0d", i), rd2, (i == 5) ? 32'hDEAD_BEEF : 32'h0);
    end

    // Write disabled
    we3 = 1'b0; a3 = 4'd3; wd3 = 32'hFFFF_FFFF;
    tick();
    a1 = 4'd3;
    #1;
    check_eq("we0_r3", rd1, 32'h0);

    // Asynchronous reset between edges
    we3 = 1'b1; a3 = 4'd7; wd3 = 32'hA5A5_A5A5; pc_next = 32'h20;
    tick();
    we3 = 1'b0;
    a1 = 4'd7; a2 = 4'd5;
    #1;
    check_eq("pre_rst_r7", rd1, 32'hA5A5_A5A5);
    check_eq("pre_rst_pc", pc, 32'h20);
    #2;
    reset = 1'b0;
    #1;
    check_eq("async_pc", pc, 32'h0);
    check_eq("async_pc8", pc_plus8, 32'h8);
    check_eq("async_r7", rd1, 32'h0);
    check_eq("async_r5", rd2, 32'h0);
    tick();
    reset = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
